// File: rtl/opcode_pipeline_n.sv
// Parametrised opcode shift pipeline with per-stage valid, stall, flush,
// flag capture on the stage 0->1 transfer and a retired-instruction counter.
module opcode_pipeline_n #(
    parameter int                 DATA_W = 8,
    parameter int                 DEPTH  = 3,
    parameter int                 FLAG_W = 7,
    parameter logic [DATA_W-1:0]  NOP    = '0,
    parameter int                 CNT_W  = 16
) (
    input  logic                    ClockIn,
    input  logic                    ResetIn,
    input  logic [DATA_W-1:0]       MEMDATA,
    input  logic                    MemValid,
    input  logic                    Stall,
    input  logic                    Flush,
    input  logic [FLAG_W-1:0]       Flags,
    output logic [DEPTH*DATA_W-1:0] StageOp,
    output logic [DEPTH-1:0]        StageValid,
    output logic [DATA_W-1:0]       PipeOut,
    output logic [FLAG_W-1:0]       FlagsOut,
    output logic [CNT_W-1:0]        Retired,
    output logic                    FetchReady
);

    logic [DATA_W-1:0] op_q  [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    // flg_q[k-1] travels with stage k; stage 0 has no flags yet
    logic [FLAG_W-1:0] flg_q [DEPTH-1];
    logic [CNT_W-1:0]  cnt_q;
    logic              retire;

    assign retire = vld_q[DEPTH-1] & (~Stall | Flush);

    always_ff @(posedge ClockIn) begin
        if (ResetIn || Flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                op_q[k]  <= NOP;
                vld_q[k] <= 1'b0;
            end
            for (int k = 0; k < DEPTH-1; k++) begin
                flg_q[k] <= '0;
            end
        end else if (!Stall) begin
            op_q[0]  <= MemValid ? MEMDATA : NOP;
            vld_q[0] <= MemValid;
            for (int k = 1; k < DEPTH; k++) begin
                op_q[k]  <= op_q[k-1];
                vld_q[k] <= vld_q[k-1];
            end
            flg_q[0] <= Flags;
            for (int k = 1; k < DEPTH-1; k++) begin
                flg_q[k] <= flg_q[k-1];
            end
        end
    end

    always_ff @(posedge ClockIn) begin
        if (ResetIn) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign StageOp[k*DATA_W +: DATA_W] = op_q[k];
    end

    assign StageValid = vld_q;
    assign PipeOut    = op_q[DEPTH-1];
    assign FlagsOut   = flg_q[DEPTH-2];
    assign Retired    = cnt_q;
    assign FetchReady = ~Stall;

endmodule

// File: tb/tb_opcode_pipeline_n.sv
// Directed bench for opcode_pipeline_n (DEPTH=3, CNT_W=4) with a
// scoreboard queue checked by a monitor on every retiring instruction.
module tb_opcode_pipeline_n;

    logic        ClockIn;
    logic        ResetIn;
    logic [7:0]  MEMDATA;
    logic        MemValid;
    logic        Stall;
    logic        Flush;
    logic [6:0]  Flags;
    logic [23:0] StageOp;
    logic [2:0]  StageValid;
    logic [7:0]  PipeOut;
    logic [6:0]  FlagsOut;
    logic [3:0]  Retired;
    logic        FetchReady;

    typedef struct packed {
        logic [7:0] op;
        logic [6:0] fl;
    } item_t;

    item_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    opcode_pipeline_n #(
        .DATA_W(8), .DEPTH(3), .FLAG_W(7), .NOP(8'h00), .CNT_W(4)
    ) dut (
        .ClockIn   (ClockIn),
        .ResetIn   (ResetIn),
        .MEMDATA   (MEMDATA),
        .MemValid  (MemValid),
        .Stall     (Stall),
        .Flush     (Flush),
        .Flags     (Flags),
        .StageOp   (StageOp),
        .StageValid(StageValid),
        .PipeOut   (PipeOut),
        .FlagsOut  (FlagsOut),
        .Retired   (Retired),
        .FetchReady(FetchReady)
    );

    initial begin
        ClockIn = 1'b0;
        forever #5 ClockIn = ~ClockIn;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [6:0] fl);
        sb.push_back('{op: op, fl: fl});
    endtask

    task automatic step();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic [6:0] f);
        MemValid = v;
        MEMDATA  = d;
        Flags    = f;
        Stall    = 1'b0;
        Flush    = 1'b0;
        step();
    endtask

    // An instruction retires at the next edge when the last stage is valid
    // and the pipe moves (advance or flush) without reset.
    initial begin
        item_t e;
        forever begin
            @(negedge ClockIn);
            if (StageValid[2] && !ResetIn && (!Stall || Flush)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", {24'd0, PipeOut}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("retire_op", {24'd0, PipeOut}, {24'd0, e.op});
                    chk("retire_flags", {25'd0, FlagsOut}, {25'd0, e.fl});
                end
            end
        end
    end

    initial begin
        ResetIn  = 1'b1;
        MEMDATA  = 8'h00;
        MemValid = 1'b0;
        Stall    = 1'b0;
        Flush    = 1'b0;
        Flags    = 7'h00;
        step();
        step();
        chk("rst_valid", {29'd0, StageValid}, 32'd0);
        chk("rst_ops", {8'd0, StageOp}, 32'd0);
        chk("rst_retired", {28'd0, Retired}, 32'd0);
        chk("rst_flags", {25'd0, FlagsOut}, 32'd0);
        chk("rst_ready", {31'd0, FetchReady}, 32'd1);
        ResetIn = 1'b0;

        // Stream
        push(8'h11, 7'h02);
        push(8'h22, 7'h03);
        push(8'h33, 7'h04);
        cyc(1'b1, 8'h11, 7'h01);
        cyc(1'b1, 8'h22, 7'h02);
        cyc(1'b1, 8'h33, 7'h03);
        chk("stream_pipeout_e3", {24'd0, PipeOut}, 32'h11);
        chk("stream_ops_e3", {8'd0, StageOp}, 32'h112233);
        cyc(1'b0, 8'h00, 7'h04);
        chk("stream_retired_e4", {28'd0, Retired}, 32'd1);
        chk("stream_pipeout_e4", {24'd0, PipeOut}, 32'h22);
        cyc(1'b0, 8'h00, 7'h00);
        chk("stream_retired_e5", {28'd0, Retired}, 32'd2);
        cyc(1'b0, 8'h00, 7'h00);
        chk("stream_retired_e6", {28'd0, Retired}, 32'd3);

        // Bubble
        push(8'h11, 7'h11);
        push(8'h33, 7'h13);
        cyc(1'b1, 8'h11, 7'h10);
        cyc(1'b0, 8'h77, 7'h11);
        chk("bubble_valid_a", {29'd0, StageValid}, 32'b010);
        chk("bubble_ops_a", {8'd0, StageOp}, 32'h001100);
        cyc(1'b1, 8'h33, 7'h12);
        chk("bubble_valid_b", {29'd0, StageValid}, 32'b101);
        chk("bubble_ops_b", {8'd0, StageOp}, 32'h110033);
        cyc(1'b0, 8'h00, 7'h13);
        chk("bubble_valid_c", {29'd0, StageValid}, 32'b010);
        chk("bubble_pipeout_nop", {24'd0, PipeOut}, 32'h00);
        chk("bubble_retired_c", {28'd0, Retired}, 32'd4);
        cyc(1'b0, 8'h00, 7'h00);
        cyc(1'b0, 8'h00, 7'h00);
        chk("bubble_retired_end", {28'd0, Retired}, 32'd5);

        // Stall
        push(8'h11, 7'h21);
        push(8'h22, 7'h22);
        push(8'h33, 7'h23);
        cyc(1'b1, 8'h11, 7'h20);
        cyc(1'b1, 8'h22, 7'h21);
        cyc(1'b1, 8'h33, 7'h22);
        MemValid = 1'b1;
        MEMDATA  = 8'hAA;
        Flags    = 7'h7F;
        Stall    = 1'b1;
        #1;
        chk("stall_ready", {31'd0, FetchReady}, 32'd0);
        step();
        step();
        chk("stall_ops", {8'd0, StageOp}, 32'h112233);
        chk("stall_valid", {29'd0, StageValid}, 32'b111);
        chk("stall_retired", {28'd0, Retired}, 32'd5);
        chk("stall_flags", {25'd0, FlagsOut}, 32'h21);
        cyc(1'b0, 8'h00, 7'h23);
        cyc(1'b0, 8'h00, 7'h00);
        cyc(1'b0, 8'h00, 7'h00);
        chk("stall_retired_end", {28'd0, Retired}, 32'd8);

        // Flush over stall
        push(8'h44, 7'h31);
        push(8'h88, 7'h34);
        cyc(1'b1, 8'h44, 7'h30);
        cyc(1'b1, 8'h55, 7'h31);
        cyc(1'b1, 8'h66, 7'h32);
        MemValid = 1'b1;
        MEMDATA  = 8'h99;
        Stall    = 1'b1;
        Flush    = 1'b1;
        step();
        chk("flush_valid", {29'd0, StageValid}, 32'd0);
        chk("flush_ops", {8'd0, StageOp}, 32'd0);
        chk("flush_retired", {28'd0, Retired}, 32'd9);
        chk("flush_flags", {25'd0, FlagsOut}, 32'd0);
        cyc(1'b1, 8'h88, 7'h33);
        chk("flush_refill", {29'd0, StageValid}, 32'b001);
        cyc(1'b0, 8'h00, 7'h34);
        cyc(1'b0, 8'h00, 7'h00);
        chk("flush_pipeout", {24'd0, PipeOut}, 32'h88);
        cyc(1'b0, 8'h00, 7'h00);
        chk("flush_retired_end", {28'd0, Retired}, 32'd10);

        // Flags
        push(8'hA1, 7'h55);
        push(8'hB2, 7'h2A);
        cyc(1'b1, 8'hA1, 7'h00);
        cyc(1'b1, 8'hB2, 7'h55);
        cyc(1'b0, 8'h00, 7'h2A);
        chk("flags_a_op", {24'd0, PipeOut}, 32'hA1);
        chk("flags_a", {25'd0, FlagsOut}, 32'h55);
        cyc(1'b0, 8'h00, 7'h00);
        chk("flags_b_op", {24'd0, PipeOut}, 32'hB2);
        chk("flags_b", {25'd0, FlagsOut}, 32'h2A);
        cyc(1'b0, 8'h00, 7'h00);
        chk("flags_retired", {28'd0, Retired}, 32'd12);

        // Wrap: 17 retirements from zero on a 4-bit counter
        ResetIn = 1'b1;
        step();
        ResetIn = 1'b0;
        chk("wrap_start", {28'd0, Retired}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            push(8'hC0 + 8'(i), 7'(i + 1));
            cyc(1'b1, 8'hC0 + 8'(i), 7'(i));
        end
        cyc(1'b0, 8'h00, 7'd17);
        cyc(1'b0, 8'h00, 7'h00);
        cyc(1'b0, 8'h00, 7'h00);
        chk("wrap_retired", {28'd0, Retired}, 32'd1);

        // Reset mid-stream
        cyc(1'b1, 8'hE1, 7'h01);
        cyc(1'b1, 8'hE2, 7'h02);
        cyc(1'b1, 8'hE3, 7'h03);
        MemValid = 1'b1;
        MEMDATA  = 8'hEE;
        ResetIn  = 1'b1;
        step();
        ResetIn  = 1'b0;
        chk("midrst_valid", {29'd0, StageValid}, 32'd0);
        chk("midrst_retired", {28'd0, Retired}, 32'd0);
        chk("midrst_ops", {8'd0, StageOp}, 32'd0);
        push(8'hF1, 7'h06);
        cyc(1'b1, 8'hF1, 7'h05);
        chk("postrst_valid", {29'd0, StageValid}, 32'b001);
        chk("postrst_op", {8'd0, StageOp}, 32'h0000F1);
        cyc(1'b0, 8'h00, 7'h06);
        cyc(1'b0, 8'h00, 7'h00);
        cyc(1'b0, 8'h00, 7'h00);
        chk("postrst_retired", {28'd0, Retired}, 32'd1);

        step();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
